// File: rtl/scr1_tcm_loader_pkg.sv
// Shared types for the TCM boot loader: FSM states, error codes
// and the last-word byte-lane mask.
package scr1_tcm_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_WRITE,
        ST_CSUM,
        ST_VERIFY,
        ST_DRAIN,
        ST_DONE,
        ST_ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_LEN  = 2'd1,
        ERR_CSUM = 2'd2,
        ERR_RB   = 2'd3
    } err_code_e;

    localparam int PK_W = 32;

    function automatic logic [3:0] lane_mask(input logic [1:0] rem);
        logic [3:0] m;
        unique case (rem)
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            2'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/scr1_tcm_loader_pack.sv
// Little-endian byte-to-word packer; lanes not yet filled stay zero
// so a short final word carries zeros in its unused lanes.
module scr1_tcm_loader_pack
    import scr1_tcm_loader_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            push,
    input  logic            last,
    input  logic [7:0]      byte_i,
    output logic [PK_W-1:0] word_o,
    output logic            word_rdy
);

    logic [PK_W-1:0] data_q, data_d;
    logic [1:0]      lane_q, lane_d;

    always_comb begin
        word_o = data_q;
        if (push) begin
            word_o[{lane_q, 3'b000} +: 8] = byte_i;
        end
        word_rdy = push && ((lane_q == 2'd3) || last);
    end

    always_comb begin
        data_d = data_q;
        lane_d = lane_q;
        if (clr) begin
            data_d = '0;
            lane_d = '0;
        end else if (word_rdy) begin
            data_d = '0;
            lane_d = '0;
        end else if (push) begin
            data_d = word_o;
            lane_d = lane_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            lane_q <= '0;
        end else begin
            data_q <= data_d;
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/scr1_tcm_loader.sv
// Boot loader driving TCM port B: stream in, pack, write, read back,
// verify both checksums and release core reset on success.
module scr1_tcm_loader
    import scr1_tcm_loader_pkg::*;
#(
    parameter int SCR1_WIDTH  = 32,
    parameter int SCR1_SIZE   = 'h00010000,
    parameter int SCR1_NBYTES = SCR1_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         s_valid,
    input  logic [7:0]                   s_data,
    output logic                         s_ready,
    output logic                         renb,
    output logic                         wenb,
    output logic [SCR1_NBYTES-1:0]       webb,
    output logic [$clog2(SCR1_SIZE)-1:2] addrb,
    output logic [SCR1_WIDTH-1:0]        datab,
    input  logic [SCR1_WIDTH-1:0]        qb,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic                         core_rst_n
);

    localparam int AW = $clog2(SCR1_SIZE);

    state_e    state_q, state_d;
    err_code_e err_code_q, err_code_d;

    logic [23:0] hdr_q, hdr_d;
    logic [31:0] n_q, n_d, w_q, w_d;
    logic [31:0] cnt_q, cnt_d, wcnt_q, wcnt_d, wcnt_nx;
    logic [31:0] load_sum_q, load_sum_d, rb_sum_q, rb_sum_d;
    logic [31:0] word_in;
    logic        rvld_q, rvld_d, rlast_q, rlast_d;

    logic                   s_ready_q, s_ready_d, renb_q, renb_d;
    logic                   wenb_q, wenb_d, busy_q, busy_d;
    logic                   done_q, done_d, err_q, err_d;
    logic                   crst_q, crst_d;
    logic [SCR1_NBYTES-1:0] webb_q, webb_d, rmask4;
    logic [AW-3:0]          addrb_q, addrb_d;
    logic [SCR1_WIDTH-1:0]  datab_q, datab_d, rd_mask;

    logic        acc, pk_push, pk_last, pk_clr, pk_rdy;
    logic [31:0] pk_word;

    assign acc     = s_valid && s_ready_q;
    assign pk_push = (state_q == ST_LOAD) && acc;
    assign pk_last = (cnt_q == n_q - 32'd1);
    assign pk_clr  = start && !busy_q;
    assign word_in = {s_data, hdr_q};
    assign wcnt_nx = wcnt_q + 32'd1;

    scr1_tcm_loader_pack u_pack (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (pk_clr),
        .push     (pk_push),
        .last     (pk_last),
        .byte_i   (s_data),
        .word_o   (pk_word),
        .word_rdy (pk_rdy)
    );

    // qb belongs to the read issued last cycle; only the final word is masked
    always_comb begin
        rmask4  = rlast_q ? lane_mask(n_q[1:0]) : '1;
        rd_mask = '0;
        for (int i = 0; i < SCR1_NBYTES; i++) begin
            rd_mask[8*i +: 8] = {8{rmask4[i]}};
        end
    end

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        hdr_d      = hdr_q;
        n_d        = n_q;
        w_d        = w_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        load_sum_d = load_sum_q;
        rb_sum_d   = rb_sum_q + (rvld_q ? (qb & rd_mask) : '0);
        rvld_d     = (state_q == ST_VERIFY);
        rlast_d    = (state_q == ST_VERIFY) && (wcnt_q == w_q - 32'd1);
        webb_d     = webb_q;
        addrb_d    = addrb_q;
        datab_d    = datab_q;
        done_d     = done_q;
        err_d      = err_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_HDR;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    cnt_d      = '0;
                    wcnt_d     = '0;
                    load_sum_d = '0;
                    rb_sum_d   = '0;
                end
            end
            ST_HDR: begin
                if (acc) begin
                    hdr_d = word_in[31:8];
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_q[1:0] == 2'd3) begin
                        n_d   = word_in;
                        w_d   = (word_in + 32'd3) >> 2;
                        cnt_d = '0;
                        if (word_in > 32'(SCR1_SIZE)) begin
                            state_d    = ST_ERR;
                            err_d      = 1'b1;
                            err_code_d = ERR_LEN;
                        end else if (word_in == '0) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (acc) begin
                    cnt_d = cnt_q + 32'd1;
                    if (pk_rdy) begin
                        state_d = ST_WRITE;
                        addrb_d = wcnt_q[AW-3:0];
                        datab_d = pk_word;
                        webb_d  = pk_last ? lane_mask(n_q[1:0]) : '1;
                    end
                end
            end
            ST_WRITE: begin
                load_sum_d = load_sum_q + datab_q;
                wcnt_d     = wcnt_nx;
                if (wcnt_q == w_q - 32'd1) begin
                    state_d = ST_CSUM;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_CSUM: begin
                if (acc) begin
                    hdr_d = word_in[31:8];
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_q[1:0] == 2'd3) begin
                        if (word_in != load_sum_q) begin
                            state_d    = ST_ERR;
                            err_d      = 1'b1;
                            err_code_d = ERR_CSUM;
                        end else if (w_q == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_VERIFY;
                            wcnt_d  = '0;
                            addrb_d = '0;
                        end
                    end
                end
            end
            ST_VERIFY: begin
                if (wcnt_q == w_q - 32'd1) begin
                    state_d = ST_DRAIN;
                end else begin
                    wcnt_d  = wcnt_nx;
                    addrb_d = wcnt_nx[AW-3:0];
                end
            end
            ST_DRAIN: begin
                if (rb_sum_d == load_sum_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = ST_ERR;
                    err_d      = 1'b1;
                    err_code_d = ERR_RB;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        s_ready_d = (state_d == ST_HDR) || (state_d == ST_LOAD)
                 || (state_d == ST_CSUM);
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE)
                 && (state_d != ST_ERR);
        wenb_d    = (state_d == ST_WRITE);
        renb_d    = (state_d == ST_VERIFY);
        crst_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            err_code_q <= ERR_NONE;
            hdr_q      <= '0;
            n_q        <= '0;
            w_q        <= '0;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            load_sum_q <= '0;
            rb_sum_q   <= '0;
            rvld_q     <= 1'b0;
            rlast_q    <= 1'b0;
            s_ready_q  <= 1'b0;
            renb_q     <= 1'b0;
            wenb_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            crst_q     <= 1'b0;
            webb_q     <= '0;
            addrb_q    <= '0;
            datab_q    <= '0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            hdr_q      <= hdr_d;
            n_q        <= n_d;
            w_q        <= w_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            load_sum_q <= load_sum_d;
            rb_sum_q   <= rb_sum_d;
            rvld_q     <= rvld_d;
            rlast_q    <= rlast_d;
            s_ready_q  <= s_ready_d;
            renb_q     <= renb_d;
            wenb_q     <= wenb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            crst_q     <= crst_d;
            webb_q     <= webb_d;
            addrb_q    <= addrb_d;
            datab_q    <= datab_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign renb       = renb_q;
    assign wenb       = wenb_q;
    assign webb       = webb_q;
    assign addrb      = addrb_q;
    assign datab      = datab_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign core_rst_n = crst_q;

endmodule
